// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad front end: debounce FSM states and kcode sizing.
// Kcode 0 means "no key"; key i reports as i+1.
package keypad_pkg;

  typedef enum logic [1:0] {
    DB_LOW  = 2'd0,
    DB_RISE = 2'd1,
    DB_HIGH = 2'd2,
    DB_FALL = 2'd3
  } db_state_t;

  localparam int KCODE_NONE = 0;

  function automatic int code_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: 2-FF synchroniser, debounce FSM with saturating down-counter, optional auto-repeat
// (KEYPAD_REPEAT_EN). Event strobes are combinational and fire in the cycle the FSM accepts a transition.
module debounce_chan
  import keypad_pkg::*;
#(
  parameter int DB_TICKS   = 500_000,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sw,
  output logic o_level,
  output logic o_pend_pos,
  output logic o_pend_neg
);

  localparam int CW = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_TICKS - 1);

  logic      r_sync1;
  logic      r_sync2;
  db_state_t r_state;
  db_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic      w_cnt_zero;
  logic      w_accept_rise;
  logic      w_rpt_fire;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DB_LOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DB_LOW:  if (r_sync2) w_state_nxt = DB_RISE;
      DB_RISE: begin
        if (!r_sync2)        w_state_nxt = DB_LOW;
        else if (w_cnt_zero) w_state_nxt = DB_HIGH;
      end
      DB_HIGH: if (!r_sync2) w_state_nxt = DB_FALL;
      DB_FALL: begin
        if (r_sync2)         w_state_nxt = DB_HIGH;
        else if (w_cnt_zero) w_state_nxt = DB_LOW;
      end
      default: w_state_nxt = DB_LOW;
    endcase
  end

  always_comb begin
    o_level       = (r_state == DB_HIGH) || (r_state == DB_FALL);
    w_accept_rise = (r_state == DB_RISE) && (w_state_nxt == DB_HIGH);
    o_pend_neg    = (r_state == DB_FALL) && (w_state_nxt == DB_LOW);
  end

  // Decrement stops at zero; the FSM leaves RISE/FALL on the zero cycle anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        DB_LOW:  if (r_sync2)  r_cnt <= CNT_LOAD;
        DB_HIGH: if (!r_sync2) r_cnt <= CNT_LOAD;
        default: if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] r_rpt;

  assign w_rpt_fire = (r_state == DB_HIGH) && (r_rpt == '0);

  // Loaded only when a press is accepted; a FALL->HIGH glitch resumes the paused count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rpt <= '0;
    end else if (w_accept_rise) begin
      r_rpt <= RW'(RPT_DELAY - 1);
    end else if (r_state == DB_HIGH) begin
      if (w_rpt_fire) r_rpt <= RW'(RPT_PERIOD - 1);
      else            r_rpt <= r_rpt - 1'b1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  // Repeat timing parameters only shape the repeat counter; the empty block keeps them referenced.
  if ((RPT_DELAY < 1) || (RPT_PERIOD < 1) || (DB_TICKS < 2)) begin : g_param_range_bad
  end

  assign o_pend_pos = w_accept_rise | w_rpt_fire;

endmodule

// File: rtl/keypad_debounce_enc.sv
// N-key debounce + event encoder; ticks/kcode one cycle after key_state changes, lowest channel first,
// release before press within a channel. Auto-repeat is built only with KEYPAD_REPEAT_EN.
module keypad_debounce_enc
  import keypad_pkg::*;
#(
  parameter int N_KEYS     = 5,
  parameter int DB_TICKS   = 500_000,
  parameter int KW         = code_w(N_KEYS),
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] sw,
  output logic [N_KEYS-1:0] key_state,
  output logic              sw_clear,
  output logic              pos_tick,
  output logic              neg_tick,
  output logic [KW-1:0]     kcode
);

  logic [N_KEYS-1:0] w_set_pos;
  logic [N_KEYS-1:0] w_set_neg;
  logic [N_KEYS-1:0] r_pend_pos;
  logic [N_KEYS-1:0] r_pend_neg;
  logic [N_KEYS-1:0] w_srv_pos;
  logic [N_KEYS-1:0] w_srv_neg;
  logic              w_any;
  logic [KW-1:0]     w_code;
  logic              r_pos_tick;
  logic              r_neg_tick;
  logic [KW-1:0]     r_kcode;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    debounce_chan #(
      .DB_TICKS   (DB_TICKS),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .i_sw       (sw[g]),
      .o_level    (key_state[g]),
      .o_pend_pos (w_set_pos[g]),
      .o_pend_neg (w_set_neg[g])
    );
  end

  assign sw_clear = ~|key_state;

  // Scan from the top so the lowest pending channel is the one left selected.
  always_comb begin
    w_srv_pos = '0;
    w_srv_neg = '0;
    w_any     = 1'b0;
    w_code    = KW'(KCODE_NONE);
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (r_pend_pos[i] || r_pend_neg[i]) begin
        w_any     = 1'b1;
        w_code    = KW'(i + 1);
        w_srv_pos = '0;
        w_srv_neg = '0;
        if (r_pend_neg[i]) w_srv_neg[i] = 1'b1;
        else               w_srv_pos[i] = 1'b1;
      end
    end
  end

  // Flags, not counters: a set while already pending merges with the pending event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_pos <= '0;
      r_pend_neg <= '0;
    end else begin
      r_pend_pos <= (r_pend_pos & ~w_srv_pos) | w_set_pos;
      r_pend_neg <= (r_pend_neg & ~w_srv_neg) | w_set_neg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos_tick <= 1'b0;
      r_neg_tick <= 1'b0;
      r_kcode    <= KW'(KCODE_NONE);
    end else begin
      r_pos_tick <= |w_srv_pos;
      r_neg_tick <= |w_srv_neg;
      if (w_any) r_kcode <= w_code;
    end
  end

  assign pos_tick = r_pos_tick;
  assign neg_tick = r_neg_tick;
  assign kcode    = r_kcode;

endmodule

// File: tb/tb_keypad_debounce_enc.sv
// Bench for keypad_debounce_enc: run-length debounce model with per-cycle compare plus directed scenarios.
module tb_keypad_debounce_enc;

  localparam int N  = 5;
  localparam int DB = 1000;
  localparam int RD = 5000;
  localparam int RP = 2000;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  sw = '0;
  logic [N-1:0]  key_state;
  logic          sw_clear;
  logic          pos_tick;
  logic          neg_tick;
  logic [KW-1:0] kcode;

  always #10 clk = ~clk;

  keypad_debounce_enc #(
    .N_KEYS     (N),
    .DB_TICKS   (DB),
    .RPT_DELAY  (RD),
    .RPT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .key_state (key_state),
    .sw_clear  (sw_clear),
    .pos_tick  (pos_tick),
    .neg_tick  (neg_tick),
    .kcode     (kcode)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Model: a key's level flips once DB+1 consecutive synchronised samples disagree with it.
  int            cyc = 0;
  logic [N-1:0]  m_d1, m_d2, m_level, m_last_s, m_run_val, m_ppos, m_pneg;
  int            m_run_len [N];
  int            m_rpt_due [N];
  logic          m_pos, m_neg, m_valid;
  logic [KW-1:0] m_kcode;
  logic          ms;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_last_s = '0; m_run_val = '0;
      m_ppos = '0; m_pneg = '0; m_pos = 1'b0; m_neg = 1'b0; m_kcode = '0; m_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_run_len[i] = 0;
        m_rpt_due[i] = 0;
      end
    end else begin
      m_valid = 1'b1;
      m_pos = 1'b0;
      m_neg = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_pneg[i] || m_ppos[i]) begin
          if (m_pneg[i]) begin m_neg = 1'b1; m_pneg[i] = 1'b0; end
          else           begin m_pos = 1'b1; m_ppos[i] = 1'b0; end
          m_kcode = KW'(i + 1);
          break;
        end
      end
      for (int i = 0; i < N; i++) begin
        ms = m_d2[i];
`ifdef KEYPAD_REPEAT_EN
        if (m_level[i]) begin
          if (m_last_s[i]) begin
            if (cyc == m_rpt_due[i]) begin
              m_ppos[i] = 1'b1;
              m_rpt_due[i] = cyc + RP;
            end
          end else begin
            m_rpt_due[i]++;
          end
        end
`endif
        if (ms == m_run_val[i]) m_run_len[i]++;
        else begin
          m_run_val[i] = ms;
          m_run_len[i] = 1;
        end
        if ((m_run_val[i] != m_level[i]) && (m_run_len[i] >= DB + 1)) begin
          m_level[i] = m_run_val[i];
          if (m_level[i]) begin
            m_ppos[i] = 1'b1;
            m_rpt_due[i] = cyc + RD;
          end else begin
            m_pneg[i] = 1'b1;
          end
        end
        m_last_s[i] = ms;
      end
      m_d2 = m_d1;
      m_d1 = sw;
    end
  end

  int ev_cyc [$];
  int ev_code [$];
  int ev_pos [$];

  always @(negedge clk) begin
    if (m_valid && reset) begin
      check($sformatf("model c%0d {ks,clr,pos,neg,kcode}", cyc),
            int'({key_state, sw_clear, pos_tick, neg_tick, kcode}),
            int'({m_level, (m_level == '0), m_pos, m_neg, m_kcode}));
      if (pos_tick || neg_tick) begin
        ev_cyc.push_back(cyc);
        ev_code.push_back(int'(kcode));
        ev_pos.push_back(int'(pos_tick));
      end
    end
  end

  function automatic int count_ev(input int from_c, input int code, input int pos);
    int n = 0;
    for (int k = 0; k < ev_cyc.size(); k++)
      if (ev_cyc[k] > from_c && ev_code[k] == code && ev_pos[k] == pos) n++;
    return n;
  endfunction

  function automatic int count_all(input int from_c);
    int n = 0;
    for (int k = 0; k < ev_cyc.size(); k++)
      if (ev_cyc[k] > from_c) n++;
    return n;
  endfunction

  function automatic int first_ev(input int from_c, input int code, input int pos);
    for (int k = 0; k < ev_cyc.size(); k++)
      if (ev_cyc[k] > from_c && ev_code[k] == code && ev_pos[k] == pos) return ev_cyc[k];
    return -100000;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int t, t2, a, b, t0, prev;
  int rpt_gap [4] = '{5000, 7000, 9000, 11000};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset key_state", int'(key_state), 0);
    check("reset sw_clear", int'(sw_clear), 1);
    check("reset ticks", int'({pos_tick, neg_tick}), 0);
    check("reset kcode", int'(kcode), 0);
    reset = 1'b1;
    wait_cyc(5);

    // 1: clean press/release on key 0
    t = cyc; sw[0] = 1'b1;
    wait_cyc(2000);
    check("t1 key_state held", int'(key_state), 1);
    check("t1 sw_clear held", int'(sw_clear), 0);
    wait_cyc(23000);
    t2 = cyc; sw[0] = 1'b0;
    wait_cyc(2000);
    check("t1 press latency", first_ev(t, 1, 1) - t, DB + 4);
    check("t1 release latency", first_ev(t2, 1, 0) - t2, DB + 4);
    check("t1 release count", count_ev(t, 1, 0), 1);
`ifndef KEYPAD_REPEAT_EN
    check("t1 press count", count_ev(t, 1, 1), 1);
`endif
    check("t1 sw_clear after", int'(sw_clear), 1);

    // 2: bouncy key 1
    t = cyc;
    for (int k = 0; k < 4; k++) begin sw[1] = ~sw[1]; wait_cyc(25); end
    sw[1] = 1'b1; wait_cyc(3000);
    for (int k = 0; k < 4; k++) begin sw[1] = ~sw[1]; wait_cyc(25); end
    sw[1] = 1'b0; wait_cyc(2000);
    check("t2 press count", count_ev(t, 2, 1), 1);
    check("t2 release count", count_ev(t, 2, 0), 1);
    check("t2 total events", count_all(t), 2);
    check("t2 press time", first_ev(t, 2, 1) - t, 100 + DB + 4);

    // 3: pulse shorter than the debounce window
    t = cyc; sw[2] = 1'b1;
    wait_cyc(900);
    check("t3 key_state[2]", int'(key_state[2]), 0);
    check("t3 sw_clear", int'(sw_clear), 1);
    sw[2] = 1'b0;
    wait_cyc(2000);
    check("t3 events", count_all(t), 0);

    // 4: keys 3 and 4 together
    t = cyc; sw[4:3] = 2'b11;
    wait_cyc(1500);
    check("t4 key_state", int'(key_state), 5'b11000);
    a = first_ev(t, 4, 1); b = first_ev(t, 5, 1);
    check("t4 key3 press time", a - t, DB + 4);
    check("t4 key4 follows", b - a, 1);
    t = cyc; sw[4:3] = 2'b00;
    wait_cyc(1500);
    a = first_ev(t, 4, 0); b = first_ev(t, 5, 0);
    check("t4 key3 release time", a - t, DB + 4);
    check("t4 key4 release follows", b - a, 1);

    // 5: reset in the middle of a rise countdown
    sw[0] = 1'b1;
    wait_cyc(500);
    reset = 1'b0;
    #3;
    check("t5 rst key_state", int'(key_state), 0);
    check("t5 rst sw_clear", int'(sw_clear), 1);
    check("t5 rst ticks", int'({pos_tick, neg_tick}), 0);
    check("t5 rst kcode", int'(kcode), 0);
    wait_cyc(4);
    sw[0] = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    t = cyc;
    wait_cyc(1500);
    check("t5 quiet after reset", count_all(t), 0);
    check("t5 kcode after reset", int'(kcode), 0);
    t = cyc; sw[0] = 1'b1;
    wait_cyc(1500);
    check("t5 fresh press time", first_ev(t, 1, 1) - t, DB + 4);
    sw[0] = 1'b0;
    wait_cyc(1500);

    // 6: long hold on key 0
    t = cyc; sw[0] = 1'b1;
    wait_cyc(12000);
    sw[0] = 1'b0;
    wait_cyc(1500);
    t0 = first_ev(t, 1, 1);
    check("t6 first press time", t0 - t, DB + 4);
`ifdef KEYPAD_REPEAT_EN
    check("t6 press count", count_ev(t, 1, 1), 5);
    prev = t0;
    for (int k = 0; k < 4; k++) begin
      prev = first_ev(prev, 1, 1);
      check($sformatf("t6 repeat %0d offset", k), prev - t0, rpt_gap[k]);
    end
`else
    check("t6 press count", count_ev(t, 1, 1), 1);
`endif
    check("t6 release count", count_ev(t, 1, 0), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
